// File: rtl/pw_hint_tx.sv
// Serial password hint transmitter: sends W bits MSB first as long (1) or
// short (0) marks on `hint`, each followed by a fixed low gap.
module pw_hint_tx #(
    parameter int SHORT_CYC = 100000,
    parameter int LONG_CYC  = 300000,
    parameter int GAP_CYC   = 200000,
    parameter int W         = 7
) (
    input  logic         clk,
    input  logic         sw7,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] password,
    output logic         hint,
    output logic         busy,
    output logic         done,
    output logic [2:0]   bit_idx
);

    localparam int MAX_CYC = (LONG_CYC > GAP_CYC) ? LONG_CYC : GAP_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam int IW      = (W > 1) ? $clog2(W) : 1;

    if (SHORT_CYC < 1 || GAP_CYC < 1 || LONG_CYC <= SHORT_CYC) begin : g_bad_timing
        $error("pw_hint_tx: need SHORT_CYC>=1, GAP_CYC>=1 and LONG_CYC>SHORT_CYC");
    end
    if (W < 1 || W > 8) begin : g_bad_width
        $error("pw_hint_tx: W must be 1..8 to fit the 3-bit bit_idx");
    end

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        GAP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0]  shreg, shreg_n;
    logic [2:0]    bit_idx_n;
    logic          done_n;
    logic [CW-1:0] mark_last;

    // Mark length follows the latched copy, never the live password input.
    assign mark_last = shreg[bit_idx[IW-1:0]] ? CW'(LONG_CYC - 1) : CW'(SHORT_CYC - 1);

    always_ff @(posedge clk) begin
        if (!sw7) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            bit_idx <= '0;
            hint    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shreg   <= shreg_n;
            bit_idx <= bit_idx_n;
            hint    <= (state_n == MARK);
            busy    <= (state_n != IDLE);
            done    <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shreg_n   = shreg;
        bit_idx_n = bit_idx;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    shreg_n   = password;
                    bit_idx_n = 3'(W - 1);
                    cnt_n     = '0;
                    state_n   = MARK;
                end
            end
            MARK: begin
                if (abort) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                end else if (cnt == mark_last) begin
                    cnt_n   = '0;
                    state_n = GAP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            GAP: begin
                if (abort) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                end else if (cnt == CW'(GAP_CYC - 1)) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd0) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx - 3'd1;
                        state_n   = MARK;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n   = IDLE;
                cnt_n     = '0;
                bit_idx_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pw_hint_tx.sv
// Self-checking bench for pw_hint_tx: a queue-based waveform model checked every
// cycle, plus directed frames with hand-computed expectations.
module tb_pw_hint_tx;

    localparam int SHORT = 2;
    localparam int LONG  = 4;
    localparam int GAPC  = 3;
    localparam int W     = 7;

    logic         clk = 1'b0;
    logic         sw7 = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] password = '0;
    logic         hint, busy, done;
    logic [2:0]   bit_idx;

    int n_cmp = 0;
    int n_bad = 0;

    pw_hint_tx #(
        .SHORT_CYC(SHORT),
        .LONG_CYC (LONG),
        .GAP_CYC  (GAPC),
        .W        (W)
    ) dut (
        .clk,
        .sw7,
        .start,
        .abort,
        .password,
        .hint,
        .busy,
        .done,
        .bit_idx
    );

    always #5 clk = ~clk;

    // Model: an accepted start expands the whole frame into a queue of per-cycle
    // output tuples; each clock pops one. Abort and reset flush the queue.
    typedef struct packed {
        logic       hint;
        logic       busy;
        logic       done;
        logic [2:0] idx;
    } exp_t;

    exp_t q[$];
    exp_t cur = '0;
    bit   model_on = 1'b0;

    always @(posedge clk) begin
        exp_t nxt;
        nxt = '0;
        if (!sw7) begin
            q.delete();
            model_on <= 1'b1;
        end else if (cur.busy && abort) begin
            q.delete();
        end else if (!cur.busy && start && !abort) begin
            q.delete();
            for (int i = W - 1; i >= 0; i--) begin
                for (int c = 0; c < (password[i] ? LONG : SHORT); c++)
                    q.push_back({1'b1, 1'b1, 1'b0, 3'(i)});
                for (int c = 0; c < GAPC; c++)
                    q.push_back({1'b0, 1'b1, 1'b0, 3'(i)});
            end
            q.push_back({1'b0, 1'b0, 1'b1, 3'd0});
            nxt = q.pop_front();
        end else if (q.size() > 0) begin
            nxt = q.pop_front();
        end
        cur <= nxt;
    end

    always @(negedge clk) begin
        if (model_on) begin
            n_cmp++;
            if ({hint, busy, done, bit_idx} !== {cur.hint, cur.busy, cur.done, cur.idx}) begin
                n_bad++;
                $display("[TB] FAIL model_cmp t=%0t got hint=%b busy=%b done=%b idx=%0d want hint=%b busy=%b done=%b idx=%0d",
                         $time, hint, busy, done, bit_idx, cur.hint, cur.busy, cur.done, cur.idx);
            end
        end
    end

    logic       hint_r[0:127];
    logic       busy_r[0:127];
    logic       done_r[0:127];
    logic [2:0] idx_r [0:127];
    int busy_cnt, hint_cnt, done_cnt, first_busy, first_done;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Cycle 0 is the cycle start is high; outputs of cycle k are sampled at its negedge.
    task automatic applyStimulus(input logic [W-1:0] pw, input logic [W-1:0] pw2,
                                 input int start2, input int abort_at, input int reset_at,
                                 input bit toggle, input int ncyc);
        busy_cnt = 0; hint_cnt = 0; done_cnt = 0; first_busy = -1; first_done = -1;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            hint_r[k] = hint; busy_r[k] = busy; done_r[k] = done; idx_r[k] = bit_idx;
            busy_cnt += int'(busy);
            hint_cnt += hint;
            done_cnt += int'(done);
            if (busy && first_busy < 0) first_busy = k;
            if (done && first_done < 0) first_done = k;
            start = (k == 0) || (k == start2);
            abort = (k == abort_at);
            sw7   = (k != reset_at);
            if (k == 0)           password = pw;
            else if (k == start2) password = pw2;
            else if (toggle)      password = k[0] ? 7'h55 : 7'h2A;
            else                  password = pw;
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; sw7 = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        sw7 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_hint", hint, 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_idx", int'(bit_idx), 0);
        sw7 = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame 1010000
        applyStimulus(7'b1010000, 7'h00, -1, -1, -1, 1'b0, 45);
        checkOutput("basic_first_busy", first_busy, 1);
        checkOutput("basic_busy_cnt", busy_cnt, 39);
        checkOutput("basic_done_cyc", first_done, 40);
        checkOutput("basic_done_cnt", done_cnt, 1);
        checkOutput("basic_hint_cnt", hint_cnt, 18);
        checkOutput("basic_hint4", hint_r[4], 1);
        checkOutput("basic_hint5", hint_r[5], 0);
        checkOutput("basic_hint8", hint_r[8], 1);
        checkOutput("basic_hint13", hint_r[13], 1);
        checkOutput("basic_hint17", hint_r[17], 0);
        checkOutput("basic_idx1", int'(idx_r[1]), 6);
        checkOutput("basic_idx10", int'(idx_r[10]), 5);
        checkOutput("basic_idx39", int'(idx_r[39]), 0);

        // All ones and all zeros
        applyStimulus(7'h7F, 7'h00, -1, -1, -1, 1'b0, 55);
        checkOutput("ones_busy_cnt", busy_cnt, 49);
        checkOutput("ones_hint_cnt", hint_cnt, 28);
        checkOutput("ones_done_cyc", first_done, 50);
        applyStimulus(7'h00, 7'h00, -1, -1, -1, 1'b0, 40);
        checkOutput("zeros_busy_cnt", busy_cnt, 35);
        checkOutput("zeros_hint_cnt", hint_cnt, 14);
        checkOutput("zeros_done_cyc", first_done, 36);

        // Start while busy, password toggling
        applyStimulus(7'b1010000, 7'h00, 10, -1, -1, 1'b1, 45);
        checkOutput("ignore_busy_cnt", busy_cnt, 39);
        checkOutput("ignore_hint_cnt", hint_cnt, 18);
        checkOutput("ignore_done_cnt", done_cnt, 1);
        checkOutput("ignore_done_cyc", first_done, 40);
        checkOutput("ignore_hint13", hint_r[13], 1);

        // Abort during second mark, fresh start at cycle 12
        applyStimulus(7'b1010000, 7'b1010000, 12, 9, -1, 1'b0, 58);
        checkOutput("abort_hint9", hint_r[9], 1);
        checkOutput("abort_hint10", hint_r[10], 0);
        checkOutput("abort_busy10", int'(busy_r[10]), 0);
        checkOutput("abort_idx10", int'(idx_r[10]), 0);
        checkOutput("abort_busy12", int'(busy_r[12]), 0);
        checkOutput("abort_hint13", hint_r[13], 1);
        checkOutput("abort_done_cnt", done_cnt, 1);
        checkOutput("abort_done_cyc", first_done, 52);

        // Reset mid-frame with start held in the reset cycle
        applyStimulus(7'b1010000, 7'h7F, 20, -1, 20, 1'b0, 30);
        checkOutput("rst_busy20", int'(busy_r[20]), 1);
        checkOutput("rst_busy21", int'(busy_r[21]), 0);
        checkOutput("rst_hint21", hint_r[21], 0);
        checkOutput("rst_idx21", int'(idx_r[21]), 0);
        checkOutput("rst_busy_cnt", busy_cnt, 20);
        checkOutput("rst_done_cnt", done_cnt, 0);

        // Back-to-back: second start in the done cycle with 7'h01
        applyStimulus(7'b1010000, 7'h01, 40, -1, -1, 1'b0, 85);
        checkOutput("b2b_busy40", int'(busy_r[40]), 0);
        checkOutput("b2b_hint41", hint_r[41], 1);
        checkOutput("b2b_idx41", int'(idx_r[41]), 6);
        checkOutput("b2b_hint71", hint_r[71], 1);
        checkOutput("b2b_hint74", hint_r[74], 1);
        checkOutput("b2b_busy_cnt", busy_cnt, 76);
        checkOutput("b2b_hint_cnt", hint_cnt, 34);
        checkOutput("b2b_done_cnt", done_cnt, 2);
        checkOutput("b2b_done78", int'(done_r[78]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
